// File: rtl/param_fifo_pkg.sv
// param_fifo_pkg: shared defaults, pointer increment helper and FIFO operation encoding
package param_fifo_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;
    typedef enum logic [1:0] {OP_IDLE, OP_PUSH, OP_POP, OP_BOTH} fifo_op_e;
    function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned depth);
        return (p + 32'd1 == depth) ? 32'd0 : p + 32'd1;
    endfunction
endpackage

// File: rtl/param_fifo_if.sv
// param_fifo_if: producer/consumer handshake, flush and status bundle of the FIFO
import param_fifo_pkg::*;
interface param_fifo_if #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  flush;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [ADDR_WIDTH:0]   count;
    logic                  almost_full;
    logic                  almost_empty;
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, almost_full, almost_empty
    );
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, almost_full, almost_empty
    );
endinterface

// File: rtl/param_fifo_mem.sv
// param_fifo_mem: one-write, one-asynchronous-read register array, not reset
module param_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
    always_ff @(posedge clk)
        if (we) mem[wr_addr] <= wr_data;
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/param_fifo_ctrl.sv
// param_fifo_ctrl: first-word-fall-through FIFO with occupancy count, threshold flags and flush
import param_fifo_pkg::*;
module param_fifo_ctrl #(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int ALMOST_FULL_TH  = (1 << ADDR_WIDTH) - 1,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input logic        clk,
    input logic        rst_n,
    param_fifo_if.slave bus
);
    localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_TH = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   cnt, cnt_nxt;
    logic                  push, pop, af, ae;
    logic [DATA_WIDTH-1:0] rd_data;
    fifo_op_e              op;
    assign bus.in_ready     = cnt != FULL;
    assign bus.out_valid    = cnt != '0;
    assign bus.out_data     = bus.out_valid ? rd_data : '0;
    assign bus.count        = cnt;
    assign bus.almost_full  = af;
    assign bus.almost_empty = ae;
    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;
    assign op   = fifo_op_e'({pop, push});
    always_comb begin
        cnt_nxt = cnt;
        case (op)
            OP_PUSH: cnt_nxt = cnt + 1'b1;
            OP_POP:  cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
        if (bus.flush) cnt_nxt = '0;
    end
    // flags track the next count so they switch on the same edge as count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            af     <= (ALMOST_FULL_TH == 0);
            ae     <= 1'b1;
        end else begin
            cnt <= cnt_nxt;
            af  <= cnt_nxt >= AF_TH;
            ae  <= cnt_nxt <= AE_TH;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ADDR_WIDTH'(ptr_inc(32'(wr_ptr), RAM_DEPTH));
                if (pop)  rd_ptr <= ADDR_WIDTH'(ptr_inc(32'(rd_ptr), RAM_DEPTH));
            end
        end
    end
    param_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk(clk),
        .we(push & ~bus.flush),
        .wr_addr(wr_ptr),
        .wr_data(bus.in_data),
        .rd_addr(rd_ptr),
        .rd_data(rd_data)
    );
endmodule

// File: tb/tb_param_fifo_ctrl.sv
// tb_param_fifo_ctrl: directed and randomized checks of param_fifo_ctrl against a queue model
module tb_param_fifo_ctrl;
    localparam int DW = 8, AW = 3, DEPTH = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0, errors = 0;
    logic [DW-1:0] q[$];
    param_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
    param_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(DEPTH-1), .ALMOST_EMPTY_TH(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_all(input string tag);
        logic [AW-1:0] diff;
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(bus.count), n);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), n < DEPTH);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), n > 0);
        chk({tag, ".out_data"}, 32'(bus.out_data), n > 0 ? 32'(q[0]) : 32'd0);
        chk({tag, ".almost_full"}, 32'(bus.almost_full), n >= DEPTH-1);
        chk({tag, ".almost_empty"}, 32'(bus.almost_empty), n <= 1);
        if (n != DEPTH) begin
            diff = dut.wr_ptr - dut.rd_ptr;
            chk({tag, ".ptr_diff"}, 32'(diff), n % DEPTH);
        end
    endtask
    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        bit push, pop;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        bus.flush     = f;
        push = v && q.size() < DEPTH;
        pop  = r && q.size() > 0;
        @(posedge clk);
        if (f) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
        @(negedge clk);
        check_all(tag);
    endtask
    initial begin
        logic [DW-1:0] pend;
        logic v, r, f, held;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        bus.flush = 1'b0;
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("idle", 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle("fill", 1, 8'(8'h11 + i), 0, 0);
        cycle("hold9", 1, 8'h19, 0, 0);
        cycle("hold9b", 1, 8'h19, 0, 0);
        for (int i = 0; i < 8; i++) cycle("drain", 0, 0, 1, 0);
        chk("wr_wrap", 32'(dut.wr_ptr), 0);
        chk("rd_wrap", 32'(dut.rd_ptr), 0);
        for (int i = 0; i < 4; i++) cycle("pre4", 1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 20; i++) cycle("steady", 1, 8'(8'h50 + i), 1, 0);
        chk("steady_wr", 32'(dut.wr_ptr), 0);
        chk("steady_rd", 32'(dut.rd_ptr), 4);
        for (int i = 0; i < 4; i++) cycle("drain2", 0, 0, 1, 0);
        cycle("bypass", 1, 8'hA5, 1, 0);
        cycle("bypass_pop", 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) cycle("refill", 1, 8'(8'h60 + i), 0, 0);
        cycle("full_both", 1, 8'hEE, 1, 0);
        chk("full_both_cnt", 32'(bus.count), 7);
        cycle("to5", 0, 0, 1, 0);
        cycle("to5", 0, 0, 1, 0);
        cycle("flush", 1, 8'h77, 1, 1);
        cycle("post_flush", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("prerst", 1, 8'(8'h90 + i), 0, 0);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("after_rst", 0, 0, 0, 0);
        pend = 8'($urandom);
        held = 1'b0;
        for (int i = 0; i < 400; i++) begin
            v = held || ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 2) != 0;
            f = $urandom_range(0, 40) == 0;
            held = v && !f && q.size() >= DEPTH;
            cycle("rand", v, pend, r, f);
            if (v && !held) pend = 8'($urandom);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
